ga_issue_queue: RTL and testbench
=================================

Name: ga_issue_queue

Overview:
- Upstream feeder for the GA coprocessor; sits between the Ibex-side GA instruction decode and the coprocessor request/response interface.
- Buffers decoded GA requests in a Depth-entry FIFO and issues them one at a time, with at most one operation outstanding.
- Captures each coprocessor response and holds it for the core under a valid/ready handshake.
- Guards against a hung coprocessor with a timeout that synthesises an error response.

Parameters:
- Depth, 4, FIFO entries; power of two, at least 2.
- TimeoutCycles, 256, maximum cycles in WAIT_RESP before a timeout error response is generated.
- CntW, $clog2(Depth+1), width of the occupancy count.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- req_valid_i  in  1  core offers a GA request.
- req_i  in  $bits(ga_req_t)  request payload; the embedded valid field is ignored.
- req_ready_o  out  1  queue accepts req_i this cycle.
- flush_i  in  1  discard all queued, not-yet-issued requests.
- ga_req_o  out  $bits(ga_req_t)  request to the coprocessor; the valid field is driven by this block.
- ga_resp_i  in  $bits(ga_resp_t)  coprocessor response (valid, ready, result, error, busy).
- resp_valid_o  out  1  held response available to the core.
- resp_result_o  out  $bits(ga_multivector_t)  held result.
- resp_error_o  out  1  coprocessor error or timeout.
- resp_timeout_o  out  1  the error was a timeout.
- resp_ready_i  in  1  core consumes the held response.
- count_o  out  CntW  current FIFO occupancy.
- busy_o  out  1  state is not IDLE, or count_o is non-zero.

Behaviour:
- Reset: synchronous on rst_i high. FIFO pointers and count go to 0, state goes to IDLE, the timeout counter goes to 0, and all outputs are 0, including ga_req_o. Reset mid-operation drops the in-flight op and any held response without notice.
- Push: when req_valid_i, req_ready_o and !flush_i are all high, req_i is written at the tail.
  - req_ready_o = !full && !flush_i.
  - No bypass: a pushed entry is issuable at the earliest one cycle later.
- Pop and push in the same cycle are allowed. count_o is unchanged in that cycle.
- Pointers are log2(Depth) bits and wrap naturally. Full and empty are decided by count.
- States:
  - IDLE: if FIFO non-empty → ISSUE.
  - ISSUE: ga_req_o = head entry with .valid = 1. If ga_resp_i.ready is high, pop the head, clear the timeout counter and go to WAIT_RESP; otherwise stay in ISSUE. ga_req_o.valid is high only in ISSUE, so it is deasserted in the cycle after acceptance, which is needed for the coprocessor to return to IDLE.
  - WAIT_RESP: ga_req_o.valid = 0 and the timeout counter increments each cycle.
    - On ga_resp_i.valid: capture result and error into the hold register, set timeout = 0, go to RESP_HOLD.
    - If the counter reaches TimeoutCycles-1 with no response: capture result = 0, error = 1, timeout = 1, go to RESP_HOLD.
    - A response and a timeout in the same cycle: the response wins.
  - RESP_HOLD: resp_valid_o = 1 with a stable payload. When resp_ready_i is high, go to IDLE, or directly to ISSUE if the FIFO is non-empty. Any ga_resp_i.valid arriving in this state is ignored.
- Back-to-back issue spacing is therefore a minimum of ISSUE(1) + WAIT_RESP(≥1) + RESP_HOLD(≥1) cycles.
- Response outputs are registered and are 0 whenever resp_valid_o is 0.
- Flush:
  - Sets count to 0 and the head pointer equal to the tail pointer at the next edge.
  - If asserted in ISSUE before acceptance (ga_resp_i.ready low), also returns to IDLE.
  - Does not abort WAIT_RESP or RESP_HOLD.
  - Flush together with a push: flush wins and the push is not accepted (req_ready_o is low).
  - Flush in the same cycle as an ISSUE acceptance: the pop completes and the remaining entries are flushed.

Test Plan:
- Single op: push one ADD request. Expect ga_req_o.valid high for exactly 1 cycle with the payload unchanged, exactly 2 cycles after the push cycle. Coprocessor returns result R 3 cycles later. Expect resp_valid_o=1, resp_result_o=R, resp_error_o=0, held until resp_ready_i.
- Fill and backpressure: with ga_resp_i.ready=0, push Depth=4 requests. Expect count_o=4 and req_ready_o=0, and a 5th push is not accepted. Release ready. Expect 4 issues in FIFO order, each issued only after the previous response is consumed. Check pointer wrap by pushing 3 more afterwards.
- Timeout: issue a request and never return a response. After exactly TimeoutCycles (256) cycles in WAIT_RESP, expect resp_valid_o=1, resp_error_o=1, resp_timeout_o=1, resp_result_o=0.
- Coprocessor error: the response arrives with error=1. Expect resp_error_o=1 and resp_timeout_o=0. With resp_ready_i held low for 10 cycles, the payload must stay stable for all 10 cycles.
- Flush: queue 3 requests, with the first in WAIT_RESP. Assert flush_i together with req_valid_i. Expect count_o=0 next cycle and the push not accepted. The in-flight response is still delivered. No further ga_req_o.valid is issued.
- Reset mid-op: assert rst_i for 1 cycle during WAIT_RESP with count_o=2. Expect all outputs 0 and state IDLE next cycle. A late ga_resp_i.valid after reset produces no resp_valid_o.

Source files
------------

// File: rtl/ga_issue_queue_pkg.sv
// Payload types shared by the GA issue queue and the coprocessor interface.
package ga_issue_queue_pkg;

    localparam int unsigned NumCoeffs = 8;
    localparam int unsigned CoeffW    = 16;

    typedef enum logic [2:0] {
        GA_OP_ADD   = 3'd0,
        GA_OP_SUB   = 3'd1,
        GA_OP_MUL   = 3'd2,
        GA_OP_WEDGE = 3'd3,
        GA_OP_DOT   = 3'd4,
        GA_OP_REV   = 3'd5,
        GA_OP_DUAL  = 3'd6,
        GA_OP_NOP   = 3'd7
    } ga_op_e;

    typedef struct packed {
        logic [NumCoeffs-1:0][CoeffW-1:0] coeff;
    } ga_multivector_t;

    typedef struct packed {
        logic            valid;
        ga_op_e          op;
        ga_multivector_t a;
        ga_multivector_t b;
    } ga_req_t;

    typedef struct packed {
        logic            valid;
        logic            ready;
        ga_multivector_t result;
        logic            error;
        logic            busy;
    } ga_resp_t;

endpackage

// File: rtl/ga_issue_queue.sv
// Buffers decoded GA requests and issues them one at a time to the coprocessor,
// holding each response for the core and synthesising an error on timeout.
module ga_issue_queue
    import ga_issue_queue_pkg::*;
#(
    parameter int unsigned Depth         = 4,
    parameter int unsigned TimeoutCycles = 256,
    parameter int unsigned CntW          = $clog2(Depth + 1)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            req_valid_i,
    input  ga_req_t         req_i,
    output logic            req_ready_o,
    input  logic            flush_i,
    output ga_req_t         ga_req_o,
    input  ga_resp_t        ga_resp_i,
    output logic            resp_valid_o,
    output ga_multivector_t resp_result_o,
    output logic            resp_error_o,
    output logic            resp_timeout_o,
    input  logic            resp_ready_i,
    output logic [CntW-1:0] count_o,
    output logic            busy_o
);

    localparam int unsigned PtrW = $clog2(Depth);
    localparam int unsigned TW   = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_RESP = 2'd2,
        RESP_HOLD = 2'd3
    } state_t;

    state_t            state;
    ga_req_t           mem [Depth];
    logic [PtrW-1:0]   wr_ptr;
    logic [PtrW-1:0]   rd_ptr;
    logic [TW-1:0]     tcnt;
    logic [CntW-1:0]   count_d;
    ga_req_t           wr_entry;
    ga_req_t           head_req;
    logic              full;
    logic              push;
    logic              pop;
    logic              start;
    logic              to_idle;
    logic              unused_fields;

    assign unused_fields = ^{req_i.valid, ga_resp_i.busy};

    assign full        = (count_o == CntW'(Depth));
    assign req_ready_o = !rst_i && !full && !flush_i;
    assign push        = req_valid_i && req_ready_o;
    assign pop         = (state == ISSUE) && ga_resp_i.ready;
    // A flush in the same cycle cancels any pending start from the FIFO.
    assign start       = (count_o != '0) && !flush_i;

    always_comb begin
        wr_entry       = req_i;
        wr_entry.valid = 1'b0;
        head_req       = mem[rd_ptr];
        head_req.valid = 1'b1;
    end

    always_comb begin
        count_d = count_o;
        if (flush_i) begin
            count_d = '0;
        end else if (push && !pop) begin
            count_d = count_o + CntW'(1);
        end else if (pop && !push) begin
            count_d = count_o - CntW'(1);
        end
    end

    // Whether the state machine lands in IDLE at the next edge; feeds busy_o.
    always_comb begin
        to_idle = 1'b0;
        case (state)
            IDLE:      to_idle = !start;
            ISSUE:     to_idle = flush_i && !ga_resp_i.ready;
            WAIT_RESP: to_idle = 1'b0;
            RESP_HOLD: to_idle = resp_ready_i && !start;
            default:   to_idle = 1'b1;
        endcase
    end

    // Entry storage carries no reset; occupancy is tracked by count_o.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= wr_entry;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state          <= IDLE;
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count_o        <= '0;
            tcnt           <= '0;
            ga_req_o       <= '0;
            resp_valid_o   <= 1'b0;
            resp_result_o  <= '0;
            resp_error_o   <= 1'b0;
            resp_timeout_o <= 1'b0;
            busy_o         <= 1'b0;
        end else begin
            count_o <= count_d;
            busy_o  <= !to_idle || (count_d != '0);

            if (push) begin
                wr_ptr <= wr_ptr + PtrW'(1);
            end
            if (flush_i) begin
                rd_ptr <= wr_ptr;
            end else if (pop) begin
                rd_ptr <= rd_ptr + PtrW'(1);
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= ISSUE;
                        ga_req_o <= head_req;
                    end
                end
                ISSUE: begin
                    if (ga_resp_i.ready) begin
                        state    <= WAIT_RESP;
                        ga_req_o <= '0;
                        tcnt     <= '0;
                    end else if (flush_i) begin
                        state    <= IDLE;
                        ga_req_o <= '0;
                    end
                end
                WAIT_RESP: begin
                    // A real response takes priority over an expiring timer.
                    if (ga_resp_i.valid) begin
                        state          <= RESP_HOLD;
                        resp_valid_o   <= 1'b1;
                        resp_result_o  <= ga_resp_i.result;
                        resp_error_o   <= ga_resp_i.error;
                        resp_timeout_o <= 1'b0;
                    end else if (tcnt == TW'(TimeoutCycles - 1)) begin
                        state          <= RESP_HOLD;
                        resp_valid_o   <= 1'b1;
                        resp_result_o  <= '0;
                        resp_error_o   <= 1'b1;
                        resp_timeout_o <= 1'b1;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                RESP_HOLD: begin
                    if (resp_ready_i) begin
                        resp_valid_o   <= 1'b0;
                        resp_result_o  <= '0;
                        resp_error_o   <= 1'b0;
                        resp_timeout_o <= 1'b0;
                        if (start) begin
                            state    <= ISSUE;
                            ga_req_o <= head_req;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    ga_req_o <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ga_issue_queue.sv
// Directed self-checking bench for ga_issue_queue.
module tb_ga_issue_queue;
    import ga_issue_queue_pkg::*;

    localparam int unsigned Depth = 4;
    localparam int unsigned CntW  = $clog2(Depth + 1);

    logic            clk;
    logic            rst;
    logic            req_valid;
    ga_req_t         req;
    logic            req_ready;
    logic            flush;
    ga_req_t         ga_req;
    ga_resp_t        ga_resp;
    logic            resp_valid;
    ga_multivector_t resp_result;
    logic            resp_error;
    logic            resp_timeout;
    logic            resp_ready;
    logic [CntW-1:0] count;
    logic            busy;

    int n_tests = 0;
    int n_fail  = 0;

    ga_issue_queue #(
        .Depth(Depth),
        .TimeoutCycles(256)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .req_valid_i(req_valid),
        .req_i(req),
        .req_ready_o(req_ready),
        .flush_i(flush),
        .ga_req_o(ga_req),
        .ga_resp_i(ga_resp),
        .resp_valid_o(resp_valid),
        .resp_result_o(resp_result),
        .resp_error_o(resp_error),
        .resp_timeout_o(resp_timeout),
        .resp_ready_i(resp_ready),
        .count_o(count),
        .busy_o(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic ga_multivector_t mv(input logic [15:0] base);
        ga_multivector_t m;
        for (int k = 0; k < 8; k++) m.coeff[k] = base + 16'(k);
        return m;
    endfunction

    function automatic ga_req_t mk_req(input ga_op_e op, input logic [15:0] base);
        ga_req_t r;
        r.valid = 1'b0;
        r.op    = op;
        r.a     = mv(base);
        r.b     = mv(base + 16'h0100);
        return r;
    endfunction

    // Issue, accept, respond and consume one queued entry.
    task automatic serve(input string tag, input ga_req_t r, input logic [15:0] rbase,
                         input int exp_cnt);
        ga_req_t exp;
        exp = r;
        exp.valid = 1'b1;
        n_tests++;
        if (ga_req !== exp) begin
            n_fail++;
            $display("FAIL %s_issue: got %h want %h", tag, ga_req, exp);
        end
        ga_resp.ready = 1'b1;
        tick();
        ga_resp.ready = 1'b0;
        n_tests++;
        if (ga_req.valid !== 1'b0 || count !== CntW'(exp_cnt)) begin
            n_fail++;
            $display("FAIL %s_accept: got valid=%b count=%0d want valid=0 count=%0d",
                     tag, ga_req.valid, count, exp_cnt);
        end
        ga_resp.valid  = 1'b1;
        ga_resp.result = mv(rbase);
        tick();
        ga_resp.valid = 1'b0;
        n_tests++;
        if (resp_valid !== 1'b1 || resp_result !== mv(rbase) || ga_req.valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_resp: got rv=%b res=%h gv=%b want rv=1 res=%h gv=0",
                     tag, resp_valid, resp_result, ga_req.valid, mv(rbase));
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        n_tests++;
        if (resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_consume: got rv=%b want 0", tag, resp_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 1'b0;
        req = '0;
        flush = 1'b0;
        ga_resp = '0;
        resp_ready = 1'b0;
        tick();
        tick();
        n_tests++;
        if (count !== '0 || ga_req !== '0 || resp_valid !== 1'b0 || busy !== 1'b0
            || resp_result !== '0 || resp_error !== 1'b0 || resp_timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got count=%0d gv=%b rv=%b busy=%b want all 0",
                     count, ga_req.valid, resp_valid, busy);
        end
        rst = 1'b0;
        #1;
        n_tests++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: got %b want 1", req_ready);
        end
    endtask

    task automatic test_single_op();
        ga_req_t r;
        ga_req_t exp;
        r = mk_req(GA_OP_ADD, 16'h0010);
        exp = r;
        exp.valid = 1'b1;
        ga_resp.ready = 1'b1;
        req_valid = 1'b1;
        req = r;
        tick();
        req_valid = 1'b0;
        n_tests++;
        if (count !== CntW'(1) || ga_req.valid !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_push: got count=%0d gv=%b busy=%b want 1 0 1",
                     count, ga_req.valid, busy);
        end
        tick();
        n_tests++;
        if (ga_req !== exp) begin
            n_fail++;
            $display("FAIL single_issue: got %h want %h", ga_req, exp);
        end
        tick();
        n_tests++;
        if (ga_req.valid !== 1'b0 || count !== '0) begin
            n_fail++;
            $display("FAIL single_one_cycle: got gv=%b count=%0d want 0 0", ga_req.valid, count);
        end
        tick();
        tick();
        ga_resp.valid  = 1'b1;
        ga_resp.result = mv(16'h0A00);
        ga_resp.error  = 1'b0;
        tick();
        ga_resp.valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (resp_valid !== 1'b1 || resp_result !== mv(16'h0A00) || resp_error !== 1'b0
                || resp_timeout !== 1'b0) begin
                n_fail++;
                $display("FAIL single_hold%0d: got rv=%b res=%h err=%b want 1 %h 0",
                         i, resp_valid, resp_result, resp_error, mv(16'h0A00));
            end
            tick();
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        n_tests++;
        if (resp_valid !== 1'b0 || resp_result !== '0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_done: got rv=%b res=%h busy=%b want 0 0 0",
                     resp_valid, resp_result, busy);
        end
    endtask

    task automatic test_fill_backpressure();
        ga_req_t q [5];
        for (int i = 0; i < 5; i++) q[i] = mk_req(ga_op_e'(3'(i + 1)), 16'(16'h2000 + i * 16'h0200));
        ga_resp = '0;
        for (int i = 0; i < 4; i++) begin
            req_valid = 1'b1;
            req = q[i];
            tick();
        end
        req = q[4];
        #1;
        n_tests++;
        if (count !== CntW'(4) || req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_full: got count=%0d ready=%b want 4 0", count, req_ready);
        end
        tick();
        req_valid = 1'b0;
        n_tests++;
        if (count !== CntW'(4)) begin
            n_fail++;
            $display("FAIL fill_fifth_rejected: got count=%0d want 4", count);
        end
        for (int i = 0; i < 4; i++) serve("fill", q[i], 16'(16'h3000 + i * 16), 3 - i);
    endtask

    task automatic test_wrap();
        ga_req_t q [3];
        for (int i = 0; i < 3; i++) q[i] = mk_req(GA_OP_WEDGE, 16'(16'h4000 + i * 16'h0300));
        ga_resp = '0;
        for (int i = 0; i < 3; i++) begin
            req_valid = 1'b1;
            req = q[i];
            tick();
        end
        req_valid = 1'b0;
        n_tests++;
        if (count !== CntW'(3)) begin
            n_fail++;
            $display("FAIL wrap_count: got %0d want 3", count);
        end
        for (int i = 0; i < 3; i++) serve("wrap", q[i], 16'(16'h4800 + i * 16), 2 - i);
    endtask

    task automatic test_timeout();
        ga_resp = '0;
        ga_resp.ready = 1'b1;
        req_valid = 1'b1;
        req = mk_req(GA_OP_MUL, 16'h5000);
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 255; i++) tick();
        n_tests++;
        if (resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_early: got rv=%b want 0", resp_valid);
        end
        tick();
        n_tests++;
        if (resp_valid !== 1'b1 || resp_error !== 1'b1 || resp_timeout !== 1'b1
            || resp_result !== '0) begin
            n_fail++;
            $display("FAIL timeout_resp: got rv=%b err=%b to=%b res=%h want 1 1 1 0",
                     resp_valid, resp_error, resp_timeout, resp_result);
        end
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        n_tests++;
        if (resp_valid !== 1'b0 || resp_timeout !== 1'b0 || resp_error !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_consume: got rv=%b to=%b err=%b want 0 0 0",
                     resp_valid, resp_timeout, resp_error);
        end
    endtask

    task automatic test_error_hold();
        ga_resp = '0;
        ga_resp.ready = 1'b1;
        req_valid = 1'b1;
        req = mk_req(GA_OP_DOT, 16'h6000);
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        ga_resp.valid  = 1'b1;
        ga_resp.error  = 1'b1;
        ga_resp.result = mv(16'h6A00);
        tick();
        // A stray response while holding must not disturb the payload.
        ga_resp.error  = 1'b0;
        ga_resp.result = mv(16'h7777);
        for (int i = 0; i < 10; i++) begin
            n_tests++;
            if (resp_valid !== 1'b1 || resp_error !== 1'b1 || resp_timeout !== 1'b0
                || resp_result !== mv(16'h6A00)) begin
                n_fail++;
                $display("FAIL error_hold%0d: got rv=%b err=%b to=%b res=%h want 1 1 0 %h",
                         i, resp_valid, resp_error, resp_timeout, resp_result, mv(16'h6A00));
            end
            tick();
        end
        ga_resp = '0;
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        n_tests++;
        if (resp_valid !== 1'b0 || resp_error !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL error_consume: got rv=%b err=%b busy=%b want 0 0 0",
                     resp_valid, resp_error, busy);
        end
    endtask

    // Leaves the first of three requests in WAIT_RESP with two still queued.
    task automatic load_three(input string tag, input logic [15:0] base);
        ga_resp = '0;
        ga_resp.ready = 1'b1;
        req_valid = 1'b1;
        req = mk_req(GA_OP_SUB, base);
        tick();
        req = mk_req(GA_OP_SUB, base + 16'h0100);
        tick();
        n_tests++;
        if (count !== CntW'(2)) begin
            n_fail++;
            $display("FAIL %s_count2: got %0d want 2", tag, count);
        end
        req = mk_req(GA_OP_SUB, base + 16'h0200);
        tick();
        req_valid = 1'b0;
        ga_resp.ready = 1'b0;
        n_tests++;
        if (count !== CntW'(2) || ga_req.valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_push_pop: got count=%0d gv=%b want 2 0", tag, count, ga_req.valid);
        end
    endtask

    task automatic test_flush();
        load_three("flush", 16'h8000);
        flush = 1'b1;
        req_valid = 1'b1;
        req = mk_req(GA_OP_REV, 16'h8F00);
        #1;
        n_tests++;
        if (req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_ready: got %b want 0", req_ready);
        end
        tick();
        flush = 1'b0;
        req_valid = 1'b0;
        n_tests++;
        if (count !== '0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_count: got count=%0d busy=%b want 0 1", count, busy);
        end
        ga_resp.valid  = 1'b1;
        ga_resp.result = mv(16'h8A00);
        tick();
        ga_resp.valid = 1'b0;
        n_tests++;
        if (resp_valid !== 1'b1 || resp_result !== mv(16'h8A00)) begin
            n_fail++;
            $display("FAIL flush_inflight: got rv=%b res=%h want 1 %h",
                     resp_valid, resp_result, mv(16'h8A00));
        end
        resp_ready = 1'b1;
        ga_resp.ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (ga_req.valid !== 1'b0) begin
                n_fail++;
                $display("FAIL flush_no_issue%0d: got gv=%b want 0", i, ga_req.valid);
            end
            tick();
        end
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_idle: got busy=%b want 0", busy);
        end
    endtask

    task automatic test_flush_in_issue();
        ga_resp = '0;
        req_valid = 1'b1;
        req = mk_req(GA_OP_DUAL, 16'h9000);
        tick();
        req_valid = 1'b0;
        tick();
        n_tests++;
        if (ga_req.valid !== 1'b1) begin
            n_fail++;
            $display("FAIL fissue_pending: got gv=%b want 1", ga_req.valid);
        end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        n_tests++;
        if (ga_req.valid !== 1'b0 || count !== '0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL fissue_abort: got gv=%b count=%0d busy=%b want 0 0 0",
                     ga_req.valid, count, busy);
        end
        ga_resp.ready = 1'b1;
        tick();
        n_tests++;
        if (ga_req.valid !== 1'b0) begin
            n_fail++;
            $display("FAIL fissue_reissue: got gv=%b want 0", ga_req.valid);
        end
    endtask

    task automatic test_reset_midop();
        load_three("rstmid", 16'hB000);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_tests++;
        if (count !== '0 || ga_req !== '0 || resp_valid !== 1'b0 || busy !== 1'b0
            || resp_result !== '0) begin
            n_fail++;
            $display("FAIL rstmid_outputs: got count=%0d gv=%b rv=%b busy=%b want all 0",
                     count, ga_req.valid, resp_valid, busy);
        end
        ga_resp.valid  = 1'b1;
        ga_resp.result = mv(16'hBA00);
        tick();
        ga_resp = '0;
        n_tests++;
        if (resp_valid !== 1'b0 || ga_req.valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_late_resp: got rv=%b gv=%b want 0 0", resp_valid, ga_req.valid);
        end
    endtask

    initial begin
        test_reset();
        test_single_op();
        test_fill_backpressure();
        test_wrap();
        test_timeout();
        test_error_hold();
        test_flush();
        test_flush_in_issue();
        test_reset_midop();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
